// File: rtl/rally_ctrl_if.sv
// Rally controller bus: collision/position/start inputs from the game, and
// serve/fault/score/status outputs back to the ball controller and display.
//  master : drives pl1_col, pl2_col, gnd_col, ball_posx, start; observes outputs
//  slave  : the rally controller itself
interface rally_ctrl_if #(
    parameter int unsigned SCORE_W = 5
);
    logic               pl1_col;
    logic               pl2_col;
    logic               gnd_col;
    logic [11:0]        ball_posx;
    logic               start;
    logic               last_touch;
    logic               ovr_touch;
    logic [SCORE_W-1:0] pl1_score;
    logic [SCORE_W-1:0] pl2_score;
    logic               point;
    logic               game_over;
    logic               winner;

    modport master (
        output pl1_col, pl2_col, gnd_col, ball_posx, start,
        input  last_touch, ovr_touch, pl1_score, pl2_score, point, game_over, winner
    );

    modport slave (
        input  pl1_col, pl2_col, gnd_col, ball_posx, start,
        output last_touch, ovr_touch, pl1_score, pl2_score, point, game_over, winner
    );
endinterface

// File: rtl/rally_ctrl.sv
// Rally/score sequencer: counts touches per possession, flags over-touch,
// awards points on ground contact by landing side, holds the rally for the
// ball controller's wait period, and detects game end.
//  clk, rst : system clock, synchronous active-high reset
//  bus      : rally_ctrl_if slave (collisions, ball x, start in; serve
//             player, over-touch, scores, point pulse, game_over/winner out)
module rally_ctrl #(
    parameter int unsigned NET_POSX   = 512,
    parameter int unsigned BALL_HALF  = 32,
    parameter int unsigned MAX_TOUCH  = 3,
    parameter int unsigned WIN_SCORE  = 15,
    parameter int unsigned SCORE_W    = 5,
    parameter int unsigned POINT_HOLD = 162_500_000
) (
    input  logic         clk,
    input  logic         rst,
    rally_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(MAX_TOUCH + 2);
    localparam int unsigned HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
    localparam int unsigned POS_W  = 13;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        RALLY     = 2'd1,
        POINT     = 2'd2,
        GAME_OVER = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                pl1_q, pl2_q, gnd_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                scorer_q, scorer_d;
    logic [SCORE_W-1:0]  pl1_score_q, pl1_score_d;
    logic [SCORE_W-1:0]  pl2_score_q, pl2_score_d;
    logic                last_touch_q, last_touch_d;
    logic                ovr_touch_q, ovr_touch_d;
    logic                point_q, point_d;
    logic                game_over_q, game_over_d;
    logic                winner_q, winner_d;

    // Rising-edge events; simultaneous player edges resolve to PL1.
    logic             pl1_e_c, pl2_e_c, gnd_e_c, touch_c, toucher_c;
    logic [POS_W-1:0] centre_c;
    logic             pl1_side_c;

    assign pl1_e_c    = bus.pl1_col & ~pl1_q;
    assign pl2_e_c    = bus.pl2_col & ~pl2_q & ~pl1_e_c;
    assign gnd_e_c    = bus.gnd_col & ~gnd_q;
    assign touch_c    = pl1_e_c | pl2_e_c;
    assign toucher_c  = pl2_e_c;
    assign centre_c   = POS_W'(bus.ball_posx) + POS_W'(BALL_HALF);
    assign pl1_side_c = (centre_c < POS_W'(NET_POSX));

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SERVE;
            pl1_q        <= 1'b0;
            pl2_q        <= 1'b0;
            gnd_q        <= 1'b0;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            hold_q       <= '0;
            scorer_q     <= 1'b0;
            pl1_score_q  <= '0;
            pl2_score_q  <= '0;
            last_touch_q <= 1'b0;
            ovr_touch_q  <= 1'b0;
            point_q      <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pl1_q        <= bus.pl1_col;
            pl2_q        <= bus.pl2_col;
            gnd_q        <= bus.gnd_col;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            hold_q       <= hold_d;
            scorer_q     <= scorer_d;
            pl1_score_q  <= pl1_score_d;
            pl2_score_q  <= pl2_score_d;
            last_touch_q <= last_touch_d;
            ovr_touch_q  <= ovr_touch_d;
            point_q      <= point_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    // Next-state and output logic.
    logic award_en_c;
    logic award_pl_c;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        hold_d       = hold_q;
        scorer_d     = scorer_q;
        pl1_score_d  = pl1_score_q;
        pl2_score_d  = pl2_score_q;
        last_touch_d = last_touch_q;
        ovr_touch_d  = ovr_touch_q;
        point_d      = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        award_en_c   = 1'b0;
        award_pl_c   = 1'b0;

        unique case (state_q)
            SERVE: begin
                if (touch_c) begin
                    owner_d = toucher_c;
                    cnt_d   = CNT_W'(1);
                    state_d = RALLY;
                end
            end
            RALLY: begin
                // A touch in the same cycle as a ground edge wins; the ground edge is lost.
                if (touch_c) begin
                    if (toucher_c == owner_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(MAX_TOUCH)) begin
                            ovr_touch_d = 1'b1;
                            award_en_c  = 1'b1;
                            award_pl_c  = ~owner_q;
                        end
                    end else begin
                        owner_d = toucher_c;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (gnd_e_c) begin
                    award_en_c = 1'b1;
                    award_pl_c = pl1_side_c;
                end
            end
            POINT: begin
                if (hold_q == HOLD_W'(POINT_HOLD - 1)) begin
                    ovr_touch_d = 1'b0;
                    cnt_d       = '0;
                    if ((scorer_q ? pl2_score_q : pl1_score_q) == SCORE_W'(WIN_SCORE)) begin
                        state_d     = GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = scorer_q;
                    end else begin
                        state_d = SERVE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            GAME_OVER: begin
                if (bus.start) begin
                    pl1_score_d  = '0;
                    pl2_score_d  = '0;
                    last_touch_d = 1'b0;
                    game_over_d  = 1'b0;
                    state_d      = SERVE;
                end
            end
            default: state_d = SERVE;
        endcase

        // Point award, shared by over-touch and ground contact.
        if (award_en_c) begin
            scorer_d     = award_pl_c;
            last_touch_d = award_pl_c;
            point_d      = 1'b1;
            hold_d       = '0;
            state_d      = POINT;
            if (award_pl_c) begin
                if (pl2_score_q != SCORE_W'(WIN_SCORE)) pl2_score_d = pl2_score_q + SCORE_W'(1);
            end else begin
                if (pl1_score_q != SCORE_W'(WIN_SCORE)) pl1_score_d = pl1_score_q + SCORE_W'(1);
            end
        end
    end

    assign bus.last_touch = last_touch_q;
    assign bus.ovr_touch  = ovr_touch_q;
    assign bus.pl1_score  = pl1_score_q;
    assign bus.pl2_score  = pl2_score_q;
    assign bus.point      = point_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Bench for rally_ctrl with a short point hold; directed vector table plus
// hand sequences for held collisions, game end and reset mid-point.
module tb_rally_ctrl;

    localparam int unsigned SCORE_W = 5;
    localparam int unsigned HOLD    = 4;

    logic clk;
    logic rst;

    rally_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    rally_ctrl #(
        .NET_POSX  (512),
        .BALL_HALF (32),
        .MAX_TOUCH (3),
        .WIN_SCORE (15),
        .SCORE_W   (SCORE_W),
        .POINT_HOLD(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        p1;
        logic        p2;
        logic        g;
        logic [11:0] x;
        logic        st;
        logic        lt;
        logic        ovr;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        pt;
        logic        go;
        logic        win;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic p1, input logic p2, input logic g, input logic [11:0] x,
                       input logic st, input logic lt, input logic ovr, input logic [4:0] s1,
                       input logic [4:0] s2, input logic pt);
        vec_t v;
        v.p1 = p1; v.p2 = p2; v.g = g; v.x = x; v.st = st;
        v.lt = lt; v.ovr = ovr; v.s1 = s1; v.s2 = s2; v.pt = pt; v.go = 1'b0; v.win = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n, input logic [11:0] x, input logic lt, input logic ovr,
                        input logic [4:0] s1, input logic [4:0] s2);
        for (int i = 0; i < n; i++) add(0, 0, 0, x, 0, lt, ovr, s1, s2, 0);
    endtask

    task automatic step(input logic p1, input logic p2, input logic g, input logic [11:0] x,
                        input logic st);
        bus.pl1_col   = p1;
        bus.pl2_col   = p2;
        bus.gnd_col   = g;
        bus.ball_posx = x;
        bus.start     = st;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.last_touch, bus.ovr_touch, bus.pl1_score, bus.pl2_score,
                    bus.point, bus.game_over, bus.winner});
    endfunction

    function automatic logic [31:0] pack_exp(input logic lt, input logic ovr, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic pt,
                                             input logic go, input logic win);
        return 32'({lt, ovr, s1, s2, pt, go, win});
    endfunction

    logic [4:0] exp_s1;
    logic       saw_bad;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        step(0, 0, 0, 12'd300, 0);
        step(0, 0, 0, 12'd300, 0);
        check("reset_outputs", outs(), 32'd0);
        rst = 1'b0;

        // Ground in SERVE ignored; PL1 touch then ground on PL1 side scores PL2.
        add(0, 0, 0, 300, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 300, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 300, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 300, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 300, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 300, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 300, 0, 1, 0, 0, 1, 0);
        idle(2, 300, 1, 0, 0, 1);
        // Back in SERVE exactly HOLD cycles later; PL2-side landing scores PL1.
        add(0, 1, 0, 600, 0, 1, 0, 0, 1, 0);
        add(0, 0, 1, 600, 0, 0, 0, 1, 1, 1);
        idle(4, 600, 0, 0, 1, 1);
        // Net boundary: centre 512 is PL2 side, centre 511 is PL1 side.
        add(1, 0, 0, 480, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 480, 0, 0, 0, 2, 1, 1);
        idle(4, 480, 0, 0, 2, 1);
        add(1, 0, 0, 479, 0, 0, 0, 2, 1, 0);
        add(0, 0, 1, 479, 0, 1, 0, 2, 2, 1);
        idle(4, 479, 1, 0, 2, 2);
        // pl1 x3, pl2 x1, pl1 x3: no over-touch; a 4th owner touch faults.
        for (int i = 0; i < 7; i++) begin
            add((i != 3), (i == 3), 0, 300, 0, 1, 0, 2, 2, 0);
            add(0, 0, 0, 300, 0, 1, 0, 2, 2, 0);
        end
        add(1, 0, 0, 300, 0, 1, 1, 2, 3, 1);
        idle(3, 300, 1, 1, 2, 3);
        add(0, 0, 0, 300, 0, 1, 0, 2, 3, 0);
        // Touch and ground together: ground dropped.
        add(1, 0, 0, 300, 0, 1, 0, 2, 3, 0);
        add(0, 0, 0, 300, 0, 1, 0, 2, 3, 0);
        add(1, 0, 1, 300, 0, 1, 0, 2, 3, 0);
        add(0, 0, 0, 300, 0, 1, 0, 2, 3, 0);
        add(0, 0, 1, 300, 0, 1, 0, 2, 4, 1);
        idle(4, 300, 1, 0, 2, 4);
        // Simultaneous serve touch goes to PL1; start outside GAME_OVER ignored.
        add(1, 1, 0, 300, 0, 1, 0, 2, 4, 0);
        add(0, 0, 0, 300, 1, 1, 0, 2, 4, 0);
        add(1, 0, 0, 300, 0, 1, 0, 2, 4, 0);
        add(0, 0, 0, 300, 0, 1, 0, 2, 4, 0);
        add(1, 0, 0, 300, 0, 1, 0, 2, 4, 0);
        add(0, 0, 0, 300, 0, 1, 0, 2, 4, 0);
        add(1, 0, 0, 300, 0, 1, 1, 2, 5, 1);
        idle(3, 300, 1, 1, 2, 5);
        add(0, 0, 0, 300, 0, 1, 0, 2, 5, 0);

        foreach (vecs[i]) begin
            step(vecs[i].p1, vecs[i].p2, vecs[i].g, vecs[i].x, vecs[i].st);
            check($sformatf("vec%0d", i), outs(),
                  pack_exp(vecs[i].lt, vecs[i].ovr, vecs[i].s1, vecs[i].s2,
                           vecs[i].pt, vecs[i].go, vecs[i].win));
        end

        // Held collision counts once: held + 3 pulses = 4 touches.
        saw_bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1, 0, 0, 300, 0);
            if (bus.point || bus.ovr_touch) saw_bad = 1'b1;
        end
        check("held_no_event", 32'(saw_bad), 32'd0);
        step(0, 0, 0, 300, 0);
        step(1, 0, 0, 300, 0);
        step(0, 0, 0, 300, 0);
        step(1, 0, 0, 300, 0);
        step(0, 0, 0, 300, 0);
        check("held_third_touch", outs(), pack_exp(1, 0, 2, 5, 0, 0, 0));
        step(1, 0, 0, 300, 0);
        check("held_fourth_touch", outs(), pack_exp(1, 1, 2, 6, 1, 0, 0));
        for (int i = 0; i < int'(HOLD); i++) step(0, 0, 0, 300, 0);
        check("held_ovr_clear", outs(), pack_exp(1, 0, 2, 6, 0, 0, 0));

        // Drive PL1 to 14, then the winning point.
        exp_s1 = 5'd2;
        while (exp_s1 < 5'd14) begin
            step(0, 1, 0, 600, 0);
            step(0, 0, 1, 600, 0);
            exp_s1 = exp_s1 + 5'd1;
            if (bus.pl1_score !== exp_s1) check("climb_score", 32'(bus.pl1_score), 32'(exp_s1));
            for (int i = 0; i < int'(HOLD); i++) step(0, 0, 0, 600, 0);
        end
        check("pl1_at_14", outs(), pack_exp(0, 0, 14, 6, 0, 0, 0));
        step(0, 1, 0, 600, 0);
        step(0, 0, 1, 600, 0);
        check("winning_point", outs(), pack_exp(0, 0, 15, 6, 1, 0, 0));
        for (int i = 0; i < int'(HOLD) - 1; i++) step(0, 0, 0, 600, 0);
        check("not_over_yet", 32'(bus.game_over), 32'd0);
        step(0, 0, 0, 600, 0);
        check("game_over", outs(), pack_exp(0, 0, 15, 6, 0, 1, 0));
        step(1, 0, 0, 300, 0);
        step(0, 0, 1, 300, 0);
        check("game_over_ignores", outs(), pack_exp(0, 0, 15, 6, 0, 1, 0));
        step(0, 0, 0, 300, 1);
        check("start_restart", outs(), pack_exp(0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 300, 0);
        step(0, 0, 1, 300, 0);
        check("first_point_new_game", outs(), pack_exp(1, 0, 0, 1, 1, 0, 0));

        // Reset in the middle of POINT.
        step(0, 0, 0, 300, 0);
        step(0, 0, 0, 300, 0);
        rst = 1'b1;
        step(0, 0, 0, 300, 0);
        check("rst_mid_point", outs(), 32'd0);
        rst = 1'b0;
        step(1, 0, 0, 600, 0);
        step(0, 0, 1, 600, 0);
        check("serve_after_rst", outs(), pack_exp(0, 0, 1, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
